// File: rtl/punc_arb_pkg.sv
// punc_mem_arbiter shared types: FSM state, read owner, starvation default.
package punc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/punc_arb_burst_gen.sv
// Loader burst address generator: latches base/len, counts beats,
// produces the wrapped beat address and the last-beat flag.
module punc_arb_burst_gen
    import punc_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [LEN_W-1:0]  ldr_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  beat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base     <= '0;
            len      <= '0;
            beat_cnt <= '0;
        end else if (start) begin
            base     <= ldr_addr;
            len      <= ldr_len;
            beat_cnt <= (ldr_len != '0) ? LEN_W'(1) : '0;
        end else if (step) begin
            beat_cnt <= last ? '0 : beat_cnt + LEN_W'(1);
        end
    end

    // Plain modular add: bursts crossing the top of memory wrap to 0.
    assign addr = base + ADDR_W'(beat_cnt);
    assign last = (beat_cnt == len);

endmodule

// File: rtl/punc_mem_arbiter.sv
// PUnC data-memory arbiter: core single beats vs. loader bursts.
// Define PUNC_ARB_AGE_EN to let a starved loader beat the core.
module punc_mem_arbiter
    import punc_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [LEN_W-1:0]  ldr_len,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              dir;
    owner_t            rd_owner;
    logic              rd_pend;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              start, step, last, starved, gnt_any, we_sel;
    logic [ADDR_W-1:0] burst_addr, addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    punc_arb_burst_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .step     (step),
        .ldr_addr (ldr_addr),
        .ldr_len  (ldr_len),
        .addr     (burst_addr),
        .last     (last)
    );

`ifdef PUNC_ARB_AGE_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign starved = (wait_cnt == WAIT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (ldr_gnt)
            wait_cnt <= '0;
        else if (state == IDLE && ldr_req && !starved)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end
`else
    assign starved = 1'b0;
`endif

    // Grants are gated by reset so an abort drops the strobe at once.
    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        we_sel    = 1'b0;
        addr_sel  = addr_q;
        wdata_sel = wdata_q;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (cpu_req && !(starved && ldr_req)) begin
                        cpu_gnt   = 1'b1;
                        we_sel    = cpu_we;
                        addr_sel  = cpu_addr;
                        wdata_sel = cpu_wdata;
                    end else if (ldr_req) begin
                        ldr_gnt   = 1'b1;
                        start     = 1'b1;
                        we_sel    = ldr_we;
                        addr_sel  = ldr_addr;
                        wdata_sel = ldr_wdata;
                        if (ldr_len != '0)
                            state_nxt = BURST;
                    end
                end
                BURST: begin
                    ldr_gnt   = 1'b1;
                    step      = 1'b1;
                    we_sel    = dir;
                    addr_sel  = burst_addr;
                    wdata_sel = ldr_wdata;
                    if (last)
                        state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    assign gnt_any   = cpu_gnt | ldr_gnt;
    assign mem_en    = gnt_any;
    assign mem_we    = gnt_any & we_sel;
    assign mem_addr  = addr_sel;
    assign mem_wdata = wdata_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dir      <= 1'b0;
            rd_owner <= OWN_CPU;
            rd_pend  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= gnt_any & ~we_sel;
            if (start)
                dir <= ldr_we;
            if (gnt_any) begin
                rd_owner <= ldr_gnt ? OWN_LDR : OWN_CPU;
                addr_q   <= addr_sel;
                wdata_q  <= wdata_sel;
            end
        end
    end

    assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    assign ldr_rvalid = rd_pend && (rd_owner == OWN_LDR);
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;
    assign busy       = (state == BURST);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Scoreboard bench for punc_mem_arbiter with a behavioural memory model.
module tb_punc_mem_arbiter;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
    logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [3:0]  ldr_len;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    punc_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_len    (ldr_len),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory behind the arbiter and the bench's expected contents.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic [15:0] cpu_rq[$];
    logic [15:0] ldr_rq[$];
    wr_t         wq[$];

    int checks = 0;
    int errors = 0;

`ifdef PUNC_ARB_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always begin
        @(negedge clk);
        #2;
        if (cpu_rvalid) begin
            if (cpu_rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_rvalid_unexpected: got 1 expected 0");
            end else
                chk("cpu_rdata", cpu_rdata, cpu_rq.pop_front());
        end
        if (ldr_rvalid) begin
            if (ldr_rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL ldr_rvalid_unexpected: got 1 expected 0");
            end else
                chk("ldr_rdata", ldr_rdata, ldr_rq.pop_front());
        end
        if (mem_en && mem_we) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_write_unexpected: addr %0h", mem_addr);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("mem_waddr", mem_addr, w.a);
                chk("mem_wdata", mem_wdata, w.d);
            end
        end
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cpu(input bit we, input logic [15:0] a,
                              input logic [15:0] d);
        if (we) begin
            wq.push_back('{a, d});
            ref_mem[a] = d;
        end else
            cpu_rq.push_back(ref_mem[a]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        drive_pt();
        drive_pt();
        rst = 1'b1;
    endtask

    task automatic cpu_access(input bit we, input logic [15:0] a,
                              input logic [15:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        chk("cpu_gnt_idle", cpu_gnt, 1);
        chk("ldr_gnt_idle", ldr_gnt, 0);
        if (cpu_gnt)
            expect_cpu(we, a, d);
        drive_pt();
        cpu_req = 1'b0;
    endtask

    // Burst of len+1 beats; optional core request mid-burst, optional
    // reset abort on a given beat (abort_beat < 0 means none).
    task automatic ldr_burst(input bit we, input logic [15:0] base,
                             input logic [3:0] len, input bit fixed,
                             input bit cpu_mid, input int abort_beat);
        logic [15:0] d [16];
        logic [15:0] ca;
        ca = 16'h3000 + 16'($urandom_range(0, 31));
        for (int i = 0; i < 16; i++)
            d[i] = fixed ? 16'h00A0 + 16'(i) : 16'($urandom);
        ldr_req = 1'b1; ldr_we = we; ldr_addr = base;
        ldr_len = len; ldr_wdata = d[0];
        for (int b = 0; b <= int'(len); b++) begin
            logic [15:0] ea;
            ea = base + 16'(b);
            @(negedge clk);
            chk("ldr_gnt_beat", ldr_gnt, 1);
            chk("busy_beat", busy, (b != 0));
            chk("cpu_gnt_stall", cpu_gnt, 0);
            if (b == abort_beat) begin
                #3;
                rst = 1'b0;
                #1;
                chk("abort_ldr_gnt", ldr_gnt, 0);
                chk("abort_mem_en", mem_en, 0);
                chk("abort_ldr_rvalid", ldr_rvalid, 0);
                drive_pt();
                ldr_req = 1'b0;
                drive_pt();
                rst = 1'b1;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_idle_gnt", ldr_gnt, 0);
                drive_pt();
                return;
            end
            if (ldr_gnt) begin
                if (we) begin
                    wq.push_back('{ea, d[b]});
                    ref_mem[ea] = d[b];
                end else
                    ldr_rq.push_back(ref_mem[ea]);
            end
            drive_pt();
            ldr_req = 1'b0;
            if (b < 15)
                ldr_wdata = d[b+1];
            if (cpu_mid && b == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
            end
        end
        @(negedge clk);
        chk("ldr_gnt_end", ldr_gnt, 0);
        chk("busy_end", busy, 0);
        if (cpu_mid) begin
            chk("cpu_gnt_after_burst", cpu_gnt, 1);
            if (cpu_gnt)
                expect_cpu(1'b0, ca, 16'h0);
        end
        drive_pt();
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        mem[16'h3000]     = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;
        mem_rdata = '0;
        cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_we = 0; ldr_addr = 0; ldr_len = 0; ldr_wdata = 0;
        do_reset();

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_cpu_gnt", cpu_gnt, 0);
            chk("rst_ldr_gnt", ldr_gnt, 0);
            chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
            chk("rst_mem_en_we", {mem_en, mem_we}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        drive_pt();

        cpu_access(1'b0, 16'h3000, 16'h0);
        cpu_access(1'b1, 16'h3001, 16'hBEEF);
        cpu_access(1'b0, 16'h3001, 16'h0);
        cpu_access(1'b0, 16'h3000, 16'h0);
        drive_pt();

        ldr_burst(1'b1, 16'hFFFE, 4'd3, 1'b1, 1'b1, -1);
        ldr_burst(1'b0, 16'hFFFE, 4'd3, 1'b0, 1'b0, -1);
        ldr_burst(1'b1, 16'h3010, 4'd0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [15:0] a;
            r = $urandom_range(0, 3);
            if (r < 2) begin
                a = 16'h3000 + 16'($urandom_range(0, 31));
                cpu_access(r[0], a, 16'($urandom));
            end else begin
                a = $urandom_range(0, 1) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                         : 16'h3000 + 16'($urandom_range(0, 31));
                ldr_burst($urandom_range(0, 1) == 1, a,
                          4'($urandom_range(0, 15)), 1'b0,
                          $urandom_range(0, 1) == 1, -1);
            end
        end

        drive_pt();
        ldr_burst(1'b0, 16'h3000, 4'd7, 1'b0, 1'b0, 2);

        // Simultaneous requests: strict priority, or aged loader wins once.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h4000; ldr_len = 4'd0;
        for (int c = 1; c <= 20; c++) begin
            bit exp_ldr;
            exp_ldr = AGE && (c == 9);
            @(negedge clk);
            chk($sformatf("prio_cpu_gnt_c%0d", c), cpu_gnt, !exp_ldr);
            chk($sformatf("prio_ldr_gnt_c%0d", c), ldr_gnt, exp_ldr);
            if (cpu_gnt)
                cpu_rq.push_back(ref_mem[16'h3000]);
            if (ldr_gnt)
                ldr_rq.push_back(ref_mem[16'h4000]);
            drive_pt();
            if (exp_ldr)
                ldr_req = 1'b0;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;

        for (int c = 0; c < 4; c++)
            drive_pt();
        chk("cpu_rq_drained", cpu_rq.size(), 0);
        chk("ldr_rq_drained", ldr_rq.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Single-port data-memory arbiter for the PUnC LC3 system. It shares one synchronous data memory between two requesters. The first is the PUnC core's load/store port: single-beat, highest priority. The second is a program/debug loader that issues non-preemptible incrementing bursts. It sits between the core datapath's memory interface and the memory array, and holds the mux, the grant FSM and the burst address generation.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `LEN_W`, 4, burst-length field width; a burst is `ldr_len+1` beats, max 16
- `STARVE_LIMIT`, 8, loader wait cycles before it beats the core (used only with the age feature)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cpu_req`  in  1  core access request, single beat
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  core address
- `cpu_wdata`  in  DATA_W  core write data
- `cpu_gnt`  out  1  access performed this cycle
- `cpu_rvalid`  out  1  read data valid, one cycle after a granted read
- `cpu_rdata`  out  DATA_W  read data
- `ldr_req`  in  1  burst request, sampled only in IDLE
- `ldr_we`  in  1  burst direction, latched at burst start
- `ldr_addr`  in  ADDR_W  burst base address, latched at start
- `ldr_len`  in  LEN_W  beats minus one, latched at start
- `ldr_wdata`  in  DATA_W  write data for the current beat
- `ldr_gnt`  out  1  beat strobe; loader advances `ldr_wdata` on each strobe
- `ldr_rvalid`  out  1  read beat valid, one cycle after its strobe
- `ldr_rdata`  out  DATA_W  read beat data
- `mem_en`, `mem_we`  out  1  memory enable and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, one-cycle latency
- `busy`  out  1  burst in progress (state BURST)

## Operation
- FSM states: IDLE and BURST. Registers: `beat_cnt`, `base`, `len`, `dir`, `rd_owner`, `wait_cnt`.
- IDLE, `cpu_req`=1 (and the loader not starved):
  - `cpu_gnt`=1 combinationally; the memory is driven from the `cpu_*` inputs that cycle.
  - The FSM stays in IDLE.
- IDLE, `cpu_req`=0, `ldr_req`=1:
  - `ldr_gnt`=1 for beat 0 at `ldr_addr`.
  - `base`, `len` and `dir` are latched.
  - If `ldr_len`≠0, go to BURST with `beat_cnt`=1. Otherwise stay in IDLE.
- BURST:
  - Drive `mem_addr`=`base+beat_cnt`, modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000.
  - `ldr_gnt`=1 and `cpu_gnt`=0 every cycle.
  - `beat_cnt` increments each cycle. On `beat_cnt==len`, return to IDLE.
- A burst is never preempted. Deasserting `ldr_req` mid-burst has no effect.
- During a burst, `cpu_req` stalls: no grant is given and the core holds its request.
- Reads:
  - `rd_owner` registers the requester of a granted read.
  - Next cycle, the matching `*_rvalid`=1 and `*_rdata`=`mem_rdata`.
  - Both `*_rdata` outputs carry `mem_rdata` continuously; only `*_rvalid` qualifies them.
- With no grant: `mem_en`=0 and `mem_we`=0, and the address and data outputs hold their last values.

## Timing
- Reset values: state IDLE; all counters 0; `cpu_gnt`, `ldr_gnt`, `cpu_rvalid`, `ldr_rvalid`, `mem_en`, `mem_we` and `busy` all 0.
- Grant latency is 0 cycles from request in IDLE. Read latency is 1 cycle from grant to rvalid.
- A burst of N beats holds the memory for exactly N consecutive cycles.
- A core request arriving in the last BURST cycle is granted in the next cycle. Core requests can be served back-to-back every cycle.
- Reset during a burst aborts it immediately, with no further strobes. Beats already written remain in memory.
- A pending `*_rvalid` is cleared by reset.

## Configuration
- `PUNC_ARB_AGE_EN` defined:
  - `wait_cnt` increments each IDLE cycle with `ldr_req`=1 and no loader grant, saturating at `STARVE_LIMIT`.
  - At `STARVE_LIMIT`, the loader wins over a simultaneous `cpu_req`.
  - `wait_cnt` clears on loader grant.
- `PUNC_ARB_AGE_EN` undefined: strict core priority, and the loader can starve. `wait_cnt` is not built.

## Structure
- Package `punc_arb_pkg`:
  - State encoding (IDLE=0, BURST=1).
  - Owner encoding (CPU=0, LDR=1).
  - `STARVE_LIMIT` default.
- Sub-module `punc_arb_burst_gen`: `base`/`len` latch, `beat_cnt`, wrapped address generation and last-beat flag.
- The FSM, arbitration and rvalid logic live in `punc_mem_arbiter`.

## Test plan
- Reset release, no requests: every output is 0 and `busy`=0 for 10 cycles.
- Core read 0x3000 with memory[0x3000]=0x1234: `cpu_gnt`=1 that cycle, then `cpu_rvalid`=1 with `cpu_rdata`=0x1234 next cycle.
- Loader write burst, base 0xFFFE, `ldr_len`=3, data 0xA0..0xA3:
  - Writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - `busy` is high for 3 cycles.
  - `cpu_req` asserted mid-burst gets no grant until the cycle after the last beat.
- `cpu_req` and `ldr_req` asserted together in IDLE without the macro: the core is granted every cycle for 20 cycles and `ldr_gnt` stays 0.
- Same stimulus with `PUNC_ARB_AGE_EN`: the loader is granted in cycle 9, i.e. after 8 waits, then the core resumes.
- Assert `rst`=0 on beat 2 of an 8-beat read burst: `ldr_gnt`, `mem_en` and `ldr_rvalid` all drop at once, and the FSM is in IDLE after release.
